addn_accum: RTL and testbench

ADDN_ACCUM -- requirements
Module: addn_accum

---
 rtl/addn_accum.sv | 85 ++++++++
 tb/tb_addn_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addn_accum.sv
// Accumulates NUM_OPS unsigned operands into one WIDTH-bit result with carry-out tracking.
// Define ADDN_ACCUM_SAT_EN to saturate to all-ones on carry; the default wraps modulo 2^WIDTH.
module addn_accum #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OPS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CntW = $clog2(NUM_OPS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_OPS - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum_ext;
  logic             carry;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_ext = {1'b0, acc_q} + {1'b0, in_data};
    carry   = sum_ext[WIDTH];
    unique case (state_q)
      StIdle: begin
        if (in_vld) begin
          acc_d   = in_data;
          cnt_d   = CntW'(1);
          ovf_d   = 1'b0;
          state_d = (NUM_OPS == 1) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (in_vld) begin
          acc_d = sum_ext[WIDTH-1:0];
`ifdef ADDN_ACCUM_SAT_EN
          // Once saturated, stay pinned at all-ones for the rest of this result.
          if (carry || ovf_q) acc_d = '1;
`endif
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: begin
        if (out_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs depend on the state register only.
  assign in_rdy  = (state_q != StDone);
  assign out_vld = (state_q == StDone);
  assign out_sum = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_addn_accum.sv
// Directed and random checks of addn_accum at (8,3), (7,1) and (7,3).
module tb_addn_accum;

  logic       clk, rst;
  logic       in_vld, in_rdy, out_vld, out_rdy, out_ovf;
  logic [7:0] in_data, out_sum;
  logic       a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_out_ovf;
  logic [6:0] a_in_data, a_out_sum;
  logic       b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_out_ovf;
  logic [6:0] b_in_data, b_out_sum;

  int n_cmp  = 0;
  int n_fail = 0;

  addn_accum #(.WIDTH(8), .NUM_OPS(3)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  addn_accum #(.WIDTH(7), .NUM_OPS(1)) dut_one (
    .clk(clk), .rst(rst), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_data(a_in_data),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  addn_accum #(.WIDTH(7), .NUM_OPS(3)) dut_w7 (
    .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_data(b_in_data),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  always #5 clk = ~clk;

  // Status word: {in_rdy, out_vld, out_ovf, out_sum}
  function automatic logic [10:0] st();
    return {in_rdy, out_vld, out_ovf, out_sum};
  endfunction

  // Present one operand for a single cycle; called just after a falling edge.
  task automatic op(input logic [7:0] d);
    in_vld  = 1'b1;
    in_data = d;
    @(negedge clk);
    in_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic take();
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_cmp++;
    if (st() !== {3'b100, 8'h00}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", st(), {3'b100, 8'h00});
    end
    op(8'h33);
    n_cmp++;
    if (st() !== {3'b100, 8'h33}) begin
      n_fail++; $display("FAIL first_load: got %h want %h", st(), {3'b100, 8'h33});
    end
    // Reset must win over a simultaneous accept.
    rst = 1'b1; in_vld = 1'b1; in_data = 8'h44;
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    n_cmp++;
    if (st() !== {3'b100, 8'h00}) begin
      n_fail++; $display("FAIL reset_override: got %h want %h", st(), {3'b100, 8'h00});
    end
  endtask

  task automatic test_basic();
    op(8'h10);
    op(8'h20);
    n_cmp++;
    if (st() !== {3'b100, 8'h30}) begin
      n_fail++; $display("FAIL basic_partial: got %h want %h", st(), {3'b100, 8'h30});
    end
    op(8'h30);
    n_cmp++;
    if (st() !== {3'b010, 8'h60}) begin
      n_fail++; $display("FAIL basic_result: got %h want %h", st(), {3'b010, 8'h60});
    end
    take();
    n_cmp++;
    if ({in_rdy, out_vld} !== 2'b10) begin
      n_fail++; $display("FAIL basic_release: got %b want 10", {in_rdy, out_vld});
    end
  endtask

  task automatic test_wrap();
    logic [10:0] exp;
`ifdef ADDN_ACCUM_SAT_EN
    exp = {3'b011, 8'hFF};
`else
    exp = {3'b011, 8'h15};
`endif
    op(8'hF0); op(8'h20); op(8'h05);
    n_cmp++;
    if (st() !== exp) begin
      n_fail++; $display("FAIL wrap_result: got %h want %h", st(), exp);
    end
    take();
  endtask

  task automatic test_gaps_stall();
    int vld_seen;
    op(8'h40); idle(2);
    n_cmp++;
    if (st() !== {3'b100, 8'h40}) begin
      n_fail++; $display("FAIL gap_hold1: got %h want %h", st(), {3'b100, 8'h40});
    end
    op(8'h41); idle(2);
    n_cmp++;
    if (st() !== {3'b100, 8'h81}) begin
      n_fail++; $display("FAIL gap_hold2: got %h want %h", st(), {3'b100, 8'h81});
    end
    op(8'h42);
    // Stalled in DONE with a stray operand offered; nothing may change.
    in_vld = 1'b1; in_data = 8'h7E;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (st() !== {3'b010, 8'hC3}) begin
        n_fail++; $display("FAIL stall_cycle%0d: got %h want %h", i, st(), {3'b010, 8'hC3});
      end
      @(negedge clk);
    end
    in_vld = 1'b0;
    vld_seen = 0;
    take();
    for (int i = 0; i < 3; i++) begin
      if (out_vld) vld_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (vld_seen != 0 || st() !== {3'b100, 8'hC3}) begin
      n_fail++; $display("FAIL single_transfer: got vld_seen=%0d st=%h want 0 %h",
                         vld_seen, st(), {3'b100, 8'hC3});
    end
  endtask

  task automatic test_reset_mid();
    op(8'h80); op(8'h90);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (st() !== {3'b100, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset: got %h want %h", st(), {3'b100, 8'h00});
    end
    op(8'h01); op(8'h02); op(8'h03);
    n_cmp++;
    if (st() !== {3'b010, 8'h06}) begin
      n_fail++; $display("FAIL post_reset_sum: got %h want %h", st(), {3'b010, 8'h06});
    end
    // Reset while a result is pending drops it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    take();
    n_cmp++;
    if (st() !== {3'b100, 8'h00}) begin
      n_fail++; $display("FAIL done_reset: got %h want %h", st(), {3'b100, 8'h00});
    end
  endtask

  task automatic test_single_op();
    a_in_vld = 1'b1; a_in_data = 7'h55;
    @(negedge clk);
    a_in_vld = 1'b0;
    n_cmp++;
    if ({a_in_rdy, a_out_vld, a_out_ovf, a_out_sum} !== {3'b010, 7'h55}) begin
      n_fail++; $display("FAIL single_op: got %h want %h",
                         {a_in_rdy, a_out_vld, a_out_ovf, a_out_sum}, {3'b010, 7'h55});
    end
    a_out_rdy = 1'b1;
    @(negedge clk);
    a_out_rdy = 1'b0;
    n_cmp++;
    if ({a_in_rdy, a_out_vld} !== 2'b10) begin
      n_fail++; $display("FAIL single_release: got %b want 10", {a_in_rdy, a_out_vld});
    end
  endtask

  task automatic test_random();
    int a, b, c, s, e_sum, e_ovf;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(127, 0));
      b = int'($urandom_range(127, 0));
      c = int'($urandom_range(127, 0));
      s = a + b;
      e_ovf = (s > 127) ? 1 : 0;
`ifdef ADDN_ACCUM_SAT_EN
      if (s > 127) s = 127;
      else s = s + c;
      if (s > 127) begin s = 127; e_ovf = 1; end
      e_sum = s;
`else
      s = (s % 128) + c;
      if (s > 127) e_ovf = 1;
      e_sum = s % 128;
`endif
      b_in_vld = 1'b1;
      b_in_data = 7'(a); @(negedge clk);
      b_in_data = 7'(b); @(negedge clk);
      b_in_data = 7'(c); @(negedge clk);
      b_in_vld = 1'b0;
      n_cmp++;
      if ({b_out_vld, b_out_ovf, b_out_sum} !== {1'b1, 1'(e_ovf), 7'(e_sum)}) begin
        n_fail++; $display("FAIL random%0d %0d+%0d+%0d: got %h want %h", i, a, b, c,
                           {b_out_vld, b_out_ovf, b_out_sum}, {1'b1, 1'(e_ovf), 7'(e_sum)});
      end
      b_out_rdy = 1'b1;
      @(negedge clk);
      b_out_rdy = 1'b0;
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    a_in_vld = 1'b0; a_in_data = '0; a_out_rdy = 1'b0;
    b_in_vld = 1'b0; b_in_data = '0; b_out_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_gaps_stall();
    test_reset_mid();
    test_single_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
